// File: rtl/fc_output_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : fc_output_collector_if
// Description : Beat-in / frame-out handshake bundle for the FC output
//               collector (producer beats in, packed softmax frame out).
// Revision    : 1.0 - initial release
// ============================================================================
interface fc_output_collector_if #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 2
) ();
    localparam int CNT_W = $clog2(LAYER_SZ + 1);

    logic                       in_valid;
    logic                       in_ready;
    logic [SIZE-1:0]            in_data;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [LAYER_SZ*SIZE-1:0]   out_values;
    logic [CNT_W-1:0]           count;
    logic                       err;

    // Environment side: drives beats in and accepts frames out.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_values, count, err
    );

    // Collector side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_values, count, err
    );
endinterface
`default_nettype wire

// File: rtl/fc_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : fc_output_collector
// Description : Gathers LAYER_SZ signed neuron outputs into one packed frame
//               for the softmax/argmax stage, with early-last error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_output_collector #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              flush,
    fc_output_collector_if.slave   bus
);
    localparam int                CNT_W    = $clog2(LAYER_SZ + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(LAYER_SZ - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(LAYER_SZ);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q,   err_d;
    logic [SIZE-1:0]    slots_q [LAYER_SZ];
    logic [SIZE-1:0]    slots_d [LAYER_SZ];

    // Handshake outputs depend on state only, so no in_* -> out_* path exists.
    assign bus.in_ready  = (state_q != ST_FULL);
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.count     = count_q;
    assign bus.err       = err_q;

    // Slot 0 occupies the most-significant SIZE bits.
    generate
        for (genvar g = 0; g < LAYER_SZ; g++) begin : g_pack
            assign bus.out_values[(LAYER_SZ-1-g)*SIZE +: SIZE] = slots_q[g];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        for (int i = 0; i < LAYER_SZ; i++) begin
            slots_d[i] = slots_q[i];
        end

        if (flush) begin
            state_d = ST_EMPTY;
            count_d = '0;
            err_d   = 1'b0;
            for (int i = 0; i < LAYER_SZ; i++) begin
                slots_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY, ST_FILL: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < LAYER_SZ; i++) begin
                            if (count_q == CNT_W'(i)) begin
                                slots_d[i] = bus.in_data;
                            end
                        end
                        // A full slot count closes the frame regardless of in_last.
                        if (count_q == LAST_IDX) begin
                            state_d = ST_FULL;
                            count_d = FULL_CNT;
                        end else if (bus.in_last) begin
                            state_d = ST_FULL;
                            count_d = FULL_CNT;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_FILL;
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        state_d = ST_EMPTY;
                        count_d = '0;
                        for (int i = 0; i < LAYER_SZ; i++) begin
                            slots_d[i] = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < LAYER_SZ; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            for (int i = 0; i < LAYER_SZ; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fc_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_output_collector
// Description : Directed self-checking bench for fc_output_collector
//               (SIZE=16, LAYER_SZ=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_output_collector;
    localparam int SIZE     = 16;
    localparam int LAYER_SZ = 2;

    logic clk;
    logic rst_n;
    logic flush;

    int n_checks;
    int n_fail;

    fc_output_collector_if #(.SIZE(SIZE), .LAYER_SZ(LAYER_SZ)) bus ();

    fc_output_collector #(.SIZE(SIZE), .LAYER_SZ(LAYER_SZ)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
    endtask

    logic [15:0] b2b_beats  [6];
    logic [31:0] b2b_frames [3];

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        flush          = 1'b0;
        bus.out_ready  = 1'b0;
        idle();
        rst_n          = 1'b0;
        #12;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_values",    64'(bus.out_values), 64'd0);
        check("reset_count",     64'(bus.count), 64'd0);
        check("reset_err",       64'(bus.err), 64'd0);
        check("reset_in_ready",  64'(bus.in_ready), 64'd1);
        #1 rst_n = 1'b1;
        cyc();

        // Basic frame with consumer ready.
        bus.out_ready = 1'b1;
        beat(16'h0800, 1'b0);
        cyc();
        check("t1_count1",     64'(bus.count), 64'd1);
        check("t1_no_valid",   64'(bus.out_valid), 64'd0);
        beat(16'h0900, 1'b1);
        cyc();
        idle();
        check("t1_out_valid",  64'(bus.out_valid), 64'd1);
        check("t1_values",     64'(bus.out_values), 64'h0800_0900);
        check("t1_count2",     64'(bus.count), 64'd2);
        check("t1_err",        64'(bus.err), 64'd0);
        check("t1_in_ready0",  64'(bus.in_ready), 64'd0);
        cyc();
        check("t1_drained",    64'(bus.out_valid), 64'd0);
        check("t1_cleared",    64'(bus.out_values), 64'd0);
        check("t1_count0",     64'(bus.count), 64'd0);

        // Backpressure: frame held while out_ready low; third beat waits.
        bus.out_ready = 1'b0;
        beat(16'h7F00, 1'b0);
        cyc();
        beat(16'h8000, 1'b1);
        cyc();
        beat(16'h1234, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid",    64'(bus.out_valid), 64'd1);
            check("bp_values",   64'(bus.out_values), 64'h7F00_8000);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_count",    64'(bus.count), 64'd2);
            cyc();
        end
        bus.out_ready = 1'b1;
        cyc();
        check("bp_released",   64'(bus.out_valid), 64'd0);
        check("bp_not_taken",  64'(bus.count), 64'd0);
        cyc();
        check("bp_third_taken", 64'(bus.count), 64'd1);
        beat(16'h5678, 1'b1);
        cyc();
        idle();
        check("bp_frame2",     64'(bus.out_values), 64'h1234_5678);
        cyc();

        // Early in_last sets sticky err and leaves slot 1 zero.
        bus.out_ready = 1'b0;
        beat(16'h7F00, 1'b1);
        cyc();
        idle();
        check("el_valid",      64'(bus.out_valid), 64'd1);
        check("el_values",     64'(bus.out_values), 64'h7F00_0000);
        check("el_count",      64'(bus.count), 64'd2);
        check("el_err",        64'(bus.err), 64'd1);
        bus.out_ready = 1'b1;
        cyc();
        beat(16'h0100, 1'b0);
        cyc();
        beat(16'h0200, 1'b1);
        cyc();
        idle();
        check("el_clean_vals", 64'(bus.out_values), 64'h0100_0200);
        check("el_err_sticky", 64'(bus.err), 64'd1);
        cyc();

        // Back-to-back: continuous traffic, one frame every 3 cycles.
        b2b_beats[0] = 16'h1111; b2b_beats[1] = 16'h2222;
        b2b_beats[2] = 16'h3333; b2b_beats[3] = 16'h4444;
        b2b_beats[4] = 16'h5555; b2b_beats[5] = 16'h6666;
        b2b_frames[0] = 32'h1111_2222;
        b2b_frames[1] = 32'h3333_4444;
        b2b_frames[2] = 32'h5555_6666;
        begin
            int idx;
            int nfr;
            int last_cyc;
            logic hs;
            idx      = 0;
            nfr      = 0;
            last_cyc = -1;
            for (int c = 0; c < 30 && nfr < 3; c++) begin
                if (idx < 6) beat(b2b_beats[idx], 1'(idx % 2));
                else         idle();
                hs = bus.in_valid && bus.in_ready;
                cyc();
                if (hs) idx++;
                if (bus.out_valid) begin
                    check("b2b_values", 64'(bus.out_values), 64'(b2b_frames[nfr]));
                    if (last_cyc >= 0) check("b2b_period", 64'(c - last_cyc), 64'd3);
                    last_cyc = c;
                    nfr++;
                end
            end
            idle();
            check("b2b_frames",   64'(nfr), 64'd3);
            check("b2b_consumed", 64'(idx), 64'd6);
        end
        cyc();
        check("b2b_idle",      64'(bus.out_valid), 64'd0);

        // Asynchronous reset mid-frame.
        beat(16'hAAAA, 1'b0);
        cyc();
        idle();
        check("rst_pre_count", 64'(bus.count), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_count",     64'(bus.count), 64'd0);
        check("rst_values",    64'(bus.out_values), 64'd0);
        check("rst_err",       64'(bus.err), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready), 64'd1);
        #2 rst_n = 1'b1;
        cyc();
        beat(16'h0100, 1'b0);
        cyc();
        beat(16'h0200, 1'b1);
        cyc();
        idle();
        check("rst_next_frame", 64'(bus.out_values), 64'h0100_0200);
        cyc();

        // Flush on the closing beat discards it and clears err.
        beat(16'h0F00, 1'b1);
        cyc();
        idle();
        check("fl_err_set",    64'(bus.err), 64'd1);
        cyc();
        beat(16'h0300, 1'b0);
        cyc();
        beat(16'h0400, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        check("fl_valid",      64'(bus.out_valid), 64'd0);
        check("fl_count",      64'(bus.count), 64'd0);
        check("fl_err",        64'(bus.err), 64'd0);
        check("fl_values",     64'(bus.out_values), 64'd0);
        beat(16'h0500, 1'b0);
        cyc();
        beat(16'h0600, 1'b1);
        cyc();
        idle();
        check("fl_next_frame", 64'(bus.out_values), 64'h0500_0600);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
